// File: rtl/buzzer_pkg.sv
// Shared types, melody indices, FSM encodings and note tables for the buzzer sequencer.
package buzzer_pkg;

  localparam int unsigned MEL_W = 3;

  localparam logic [MEL_W-1:0] MEL_FX0 = 3'd0;
  localparam logic [MEL_W-1:0] MEL_FX1 = 3'd1;
  localparam logic [MEL_W-1:0] MEL_FX2 = 3'd2;
  localparam logic [MEL_W-1:0] MEL_FX3 = 3'd3;
  localparam logic [MEL_W-1:0] MEL_BGM = 3'd4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_PLAY = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  typedef struct packed {
    logic [15:0] half_period;  // clk cycles per half wave, 0 = rest
    logic [7:0]  dur_ticks;    // note length in ticks, 0 behaves as 1
    logic        last;         // final note of the melody
  } note_t;

  function automatic note_t mk_note(input logic [15:0] hp, input logic [7:0] dur,
                                    input logic lst);
    note_t n;
    n.half_period = hp;
    n.dur_ticks   = dur;
    n.last        = lst;
    return n;
  endfunction

  // Production melodies for a 50 MHz clock and 1 ms ticks; unused slots are a 1 ms rest.
  function automatic note_t prod_note(input logic [MEL_W-1:0] mel, input logic [7:0] step);
    note_t n;
    n = mk_note(16'd0, 8'd1, 1'b1);
    case ({mel, step})
      {MEL_FX0, 8'd0}: n = mk_note(16'd31888, 8'd60,  1'b0);  // coin: G5
      {MEL_FX0, 8'd1}: n = mk_note(16'd23889, 8'd120, 1'b1);  //       C6
      {MEL_FX1, 8'd0}: n = mk_note(16'd47801, 8'd40,  1'b0);  // jump: C5
      {MEL_FX1, 8'd1}: n = mk_note(16'd37936, 8'd40,  1'b0);  //       E5
      {MEL_FX1, 8'd2}: n = mk_note(16'd31888, 8'd80,  1'b1);  //       G5
      {MEL_FX2, 8'd0}: n = mk_note(16'd56818, 8'd30,  1'b0);  // hit:  A4
      {MEL_FX2, 8'd1}: n = mk_note(16'd0,     8'd20,  1'b0);
      {MEL_FX2, 8'd2}: n = mk_note(16'd56818, 8'd30,  1'b1);
      {MEL_FX3, 8'd0}: n = mk_note(16'd31888, 8'd150, 1'b0);  // game over
      {MEL_FX3, 8'd1}: n = mk_note(16'd37936, 8'd150, 1'b0);
      {MEL_FX3, 8'd2}: n = mk_note(16'd47801, 8'd150, 1'b0);
      {MEL_FX3, 8'd3}: n = mk_note(16'd56818, 8'd250, 1'b1);
      {MEL_BGM, 8'd0}: n = mk_note(16'd47801, 8'd200, 1'b0);  // background loop
      {MEL_BGM, 8'd1}: n = mk_note(16'd37936, 8'd200, 1'b0);
      {MEL_BGM, 8'd2}: n = mk_note(16'd31888, 8'd200, 1'b0);
      {MEL_BGM, 8'd3}: n = mk_note(16'd37936, 8'd200, 1'b0);
      {MEL_BGM, 8'd4}: n = mk_note(16'd47801, 8'd250, 1'b0);
      {MEL_BGM, 8'd5}: n = mk_note(16'd0,     8'd100, 1'b1);
      default:         n = mk_note(16'd0,     8'd1,   1'b1);
    endcase
    return n;
  endfunction

  // Small table with short periods so a simulation covers whole melodies quickly.
  function automatic note_t test_note(input logic [MEL_W-1:0] mel, input logic [7:0] step);
    note_t n;
    n = mk_note(16'd0, 8'd1, 1'b1);
    case ({mel, step})
      {MEL_FX1, 8'd0}: n = mk_note(16'd4, 8'd3, 1'b0);
      {MEL_FX1, 8'd1}: n = mk_note(16'd0, 8'd2, 1'b1);
      {MEL_FX3, 8'd0}: n = mk_note(16'd2, 8'd1, 1'b1);
      {MEL_BGM, 8'd0}: n = mk_note(16'd3, 8'd1, 1'b0);
      {MEL_BGM, 8'd1}: n = mk_note(16'd5, 8'd1, 1'b1);
      default:         n = mk_note(16'd0, 8'd1, 1'b1);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/buzzer_if.sv
// Request/status bundle between game logic (master) and the buzzer sequencer (slave).
interface buzzer_if;
  import buzzer_pkg::*;

  logic [3:0]       fx_req;
  logic             bgm_en;
  logic             buzz;
  logic             busy;
  logic [MEL_W-1:0] cur_mel;
  logic             done;

  modport master (output fx_req, output bgm_en,
                  input  buzz, input busy, input cur_mel, input done);
  modport slave  (input  fx_req, input bgm_en,
                  output buzz, output busy, output cur_mel, output done);
endinterface

// File: rtl/buzzer_note_rom.sv
// Registered note table; data for an address appears one cycle after it is presented.
module buzzer_note_rom
  import buzzer_pkg::*;
#(
  parameter int unsigned STEP_W  = 4,
  parameter int unsigned SIM_ROM = 0
) (
  input  logic                    clk,
  input  logic [MEL_W+STEP_W-1:0] addr_i,
  output note_t                   note_o
);

  logic [MEL_W-1:0] mel;
  logic [7:0]       step;
  note_t            note_q;

  assign mel  = addr_i[MEL_W+STEP_W-1 -: MEL_W];
  assign step = 8'(addr_i[STEP_W-1:0]);

  // Table lookup, registered.
  always_ff @(posedge clk) begin
    note_q <= (SIM_ROM != 0) ? test_note(mel, step) : prod_note(mel, step);
  end

  assign note_o = note_q;

endmodule

// File: rtl/buzzer_seq.sv
// Buzzer sequencer: arbitrates four effects and a looping BGM, plays notes from the ROM.
module buzzer_seq
  import buzzer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_TICKS = 10,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned SIM_ROM   = 0
) (
  input  logic     clk,
  input  logic     rst,
  buzzer_if.slave  bus
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_MAX = (GAP_TICKS == 0) ? 1 : GAP_TICKS;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned ADDR_W  = MEL_W + STEP_W;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_MAX);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  state_t            state_q, state_d;
  logic [MEL_W-1:0]  mel_q, mel_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [15:0]       tone_q, tone_d;
  logic [7:0]        dur_q, dur_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              buzz_q, buzz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        fx_prev_q;

  logic [1:0]        fx_win;
  logic [MEL_W-1:0]  win_mel;
  logic              fx_any;
  logic [3:0]        fx_rise;
  logic              preempt;
  logic [ADDR_W-1:0] rom_addr;
  note_t             note;

  // Free-running duration tick, unaffected by melody changes.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  // Highest set request bit wins.
  always_comb begin
    fx_win = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.fx_req[i]) fx_win = 2'(i);
    end
  end

  assign fx_any  = |bus.fx_req;
  assign fx_rise = bus.fx_req & ~fx_prev_q;
  assign win_mel = {1'b0, fx_win};
  // BGM yields to any effect; an equal effect only restarts on a fresh edge.
  assign preempt = fx_any && ((mel_q == MEL_BGM) || (win_mel > mel_q) ||
                              ((win_mel == mel_q) && fx_rise[fx_win]));

  // Address from next-state so the note is ready while in LOAD.
  assign rom_addr = {mel_d, step_d};

  buzzer_note_rom #(
    .STEP_W  (STEP_W),
    .SIM_ROM (SIM_ROM)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .note_o (note)
  );

  // Next-state: melody stepping, tone generation, duration/gap timing, pre-emption.
  always_comb begin
    state_d = state_q;
    mel_d   = mel_q;
    step_d  = step_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    buzz_d  = buzz_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        buzz_d = 1'b0;
        if (fx_any) begin
          mel_d   = win_mel;
          step_d  = '0;
          state_d = ST_LOAD;
        end else if (bus.bgm_en) begin
          mel_d   = MEL_BGM;
          step_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        buzz_d  = 1'b0;
        tone_d  = note.half_period - 16'd1;
        dur_d   = (note.dur_ticks == 8'd0) ? 8'd1 : note.dur_ticks;
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (note.half_period == 16'd0) begin
          buzz_d = 1'b0;
        end else if (tone_q == 16'd0) begin
          buzz_d = ~buzz_q;
          tone_d = note.half_period - 16'd1;
        end else begin
          tone_d = tone_q - 16'd1;
        end
        if (tick) begin
          if (dur_q > 8'd1) begin
            dur_d = dur_q - 8'd1;
          end else begin
            buzz_d  = 1'b0;
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end
      end
      default: begin
        buzz_d = 1'b0;
        if (tick) begin
          if (gap_q > GAP_W'(1)) begin
            gap_d = gap_q - GAP_W'(1);
          end else if (mel_q == MEL_BGM) begin
            if (!bus.bgm_en) begin
              state_d = ST_IDLE;
            end else begin
              step_d  = note.last ? '0 : step_q + STEP_W'(1);
              state_d = ST_LOAD;
            end
          end else if (note.last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
    endcase

    if ((state_q != ST_IDLE) && preempt) begin
      mel_d   = win_mel;
      step_d  = '0;
      buzz_d  = 1'b0;
      done_d  = 1'b0;
      state_d = ST_LOAD;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mel_q     <= MEL_FX0;
      step_q    <= '0;
      tone_q    <= '0;
      dur_q     <= '0;
      gap_q     <= '0;
      buzz_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fx_prev_q <= '0;
    end else begin
      state_q   <= state_d;
      mel_q     <= mel_d;
      step_q    <= step_d;
      tone_q    <= tone_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      buzz_q    <= buzz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fx_prev_q <= bus.fx_req;
    end
  end

  assign bus.buzz    = buzz_q;
  assign bus.busy    = busy_q;
  assign bus.cur_mel = mel_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_buzzer_seq.sv
// Directed bench for buzzer_seq with the small test table, TICK_DIV=10, GAP_TICKS=1.
// Cycle t=0 is the first PLAY cycle; requests are issued at t=-2 with tick phase aligned so
// ticks fall on t = 9, 19, 29, ...
module tb_buzzer_seq;
  import buzzer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   n           = 0;

  always #5 clk = ~clk;

  buzzer_if bus ();

  buzzer_seq #(
    .TICK_DIV  (10),
    .GAP_TICKS (1),
    .STEP_W    (4),
    .SIM_ROM   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic chk(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all(input string sc, input int t, input int eb, input int ey,
                         input int em, input int ed, input bit mel_valid);
    chk({sc, ".buzz"}, t, 8'(bus.buzz), 8'(eb));
    chk({sc, ".busy"}, t, 8'(bus.busy), 8'(ey));
    chk({sc, ".done"}, t, 8'(bus.done), 8'(ed));
    if (mel_valid) chk({sc, ".cur_mel"}, t, 8'(bus.cur_mel), 8'(em));
  endtask

  // Align so that the request cycle sits two cycles before a tick-phase 0 cycle.
  task automatic wait_phase();
    for (int i = 0; i < 10; i++) begin
      if (n % 10 != 8) step();
    end
  endtask

  function automatic int bgm_buzz(input int t);
    if (t >= 0  && t <= 9)  return (t / 3) % 2;
    if (t >= 21 && t <= 29) return ((t - 21) / 5) % 2;
    if (t >= 41 && t <= 49) return ((t - 41) / 3) % 2;
    if (t >= 61 && t <= 69) return ((t - 61) / 5) % 2;
    if (t >= 81 && t <= 89) return ((t - 81) / 3) % 2;
    return 0;
  endfunction

  initial begin
    int eb;
    int em;
    rst        = 1'b1;
    bus.fx_req = 4'b0000;
    bus.bgm_en = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    n   = 0;
    chk_all("reset", 0, 0, 0, 0, 0, 1'b1);

    // Reset in the middle of an fx1 note.
    wait_phase();
    bus.fx_req = 4'b0010;
    step();
    bus.fx_req = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) step();
    chk_all("pre_rst", 5, 1, 1, 1, 0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n   = 0;
    chk_all("mid_rst", 0, 0, 0, 0, 0, 1'b1);
    for (int t = 1; t <= 60; t++) begin
      chk_all("post_rst", t, 0, 0, 0, 0, 1'b0);
      step();
    end

    // fx1 complete: tone, rest, gaps, single done.
    wait_phase();
    for (int t = -2; t <= 75; t++) begin
      bus.fx_req = (t == -2) ? 4'b0010 : 4'b0000;
      eb = (t >= 0 && t <= 29) ? (t / 4) % 2 : 0;
      chk_all("fx1", t, eb, (t >= -1 && t <= 69) ? 1 : 0, 1, (t == 70) ? 1 : 0, t >= -1);
      step();
    end

    // fx1 pre-empted by fx3 mid-note.
    wait_phase();
    for (int t = -2; t <= 35; t++) begin
      bus.fx_req = (t == -2) ? 4'b0010 : (t == 13) ? 4'b1000 : 4'b0000;
      if (t >= 0 && t <= 13)       eb = (t / 4) % 2;
      else if (t == 17 || t == 18) eb = 1;
      else                         eb = 0;
      em = (t <= 13) ? 1 : 3;
      chk_all("pre3", t, eb, (t >= -1 && t <= 29) ? 1 : 0, em, (t == 30) ? 1 : 0, t >= -1);
      step();
    end

    // fx3 playing, lower fx0 request ignored.
    wait_phase();
    for (int t = -2; t <= 25; t++) begin
      bus.fx_req = (t == -2) ? 4'b1000 : (t >= 3 && t <= 5) ? 4'b0001 : 4'b0000;
      eb = (t >= 0 && t <= 9) ? (t / 2) % 2 : 0;
      chk_all("ign0", t, eb, (t >= -1 && t <= 19) ? 1 : 0, 3, (t == 20) ? 1 : 0, t >= -1);
      step();
    end

    // BGM loops, then stops at end of GAP once disabled.
    wait_phase();
    for (int t = -2; t <= 105; t++) begin
      bus.bgm_en = (t < 85);
      chk_all("bgm", t, bgm_buzz(t), (t >= -1 && t <= 99) ? 1 : 0, 4, 0, t >= -1);
      step();
    end

    // BGM pre-empted by fx1, then restarts from step 0.
    wait_phase();
    bus.bgm_en = 1'b1;
    for (int t = -2; t <= 76; t++) begin
      bus.fx_req = (t == 4) ? 4'b0010 : 4'b0000;
      if (t >= 0 && t <= 4)       eb = (t / 3) % 2;
      else if (t >= 6 && t <= 29) eb = ((t - 6) / 4) % 2;
      else if (t >= 72)           eb = ((t - 72) / 3) % 2;
      else                        eb = 0;
      em = (t <= 4) ? 4 : (t <= 70) ? 1 : 4;
      chk_all("bgm_pre", t, eb, (t == -2 || t == 70) ? 0 : 1, em, (t == 70) ? 1 : 0, t >= -1);
      step();
    end
    bus.bgm_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
